// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register transaction controller.
// States, command-bit index and status-byte bit positions.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    WR_REQ,
    DATA
  } state_e;

  localparam int OVERRUN_BIT = 0;
  localparam int TIMEOUT_BIT = 1;

  function automatic int rw_bit(input int w);
    return w - 1;
  endfunction

  localparam int RW_BIT = rw_bit(8);

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register bus between the SPI transaction controller and the register file.
// req/ack handshake: we/re held until a one-cycle ack.
interface spi_reg_ctrl_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-2:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata,
    input  reg_ack
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata,
    output reg_ack
  );

endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder sequencing auto-incrementing register reads/writes.
// Optional bus timeout via `define SPI_REG_CTRL_TIMEOUT_EN.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_byte,
  output logic              busy,
  output logic              overrun,
  spi_reg_ctrl_if.master    bus
);

  localparam int AW = DATA_W - 1;

  state_e            state_q, state_d;
  logic              cs_n_q;
  logic              rw_q, rw_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              overrun_q, overrun_d;
  logic              terr_q, terr_d;
  logic              abort_q, abort_d;
  logic              fall, rise, tmo, end_now;
  logic [DATA_W-1:0] status;

  assign fall = cs_n_q & ~cs_n;
  assign rise = ~cs_n_q & cs_n;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == RD_REQ || state_q == WR_REQ)
        && state_d == state_q)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign tmo = 1'b0;
`endif

  always_comb begin
    status              = '0;
    status[OVERRUN_BIT] = overrun_q;
    status[TIMEOUT_BIT] = terr_q;
  end

  // A cs_n rise during a request is remembered until the handshake ends.
  assign end_now = abort_q | rise;

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    overrun_d = overrun_q;
    terr_d    = terr_q;
    abort_d   = abort_q;
    unique case (state_q)
      IDLE: begin
        tx_d = status;
        if (fall) state_d = CMD;
      end
      CMD: begin
        if (rise) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          rw_d      = rx_byte[rw_bit(DATA_W)];
          addr_d    = rx_byte[AW-1:0];
          overrun_d = 1'b0;
          terr_d    = 1'b0;
          state_d   = rx_byte[rw_bit(DATA_W)] ? RD_REQ : DATA;
        end
      end
      RD_REQ, WR_REQ: begin
        if (rise) abort_d = 1'b1;
        if (rx_valid) overrun_d = 1'b1;
        if (bus.reg_ack) begin
          addr_d  = addr_q + 1'b1;
          abort_d = 1'b0;
          state_d = end_now ? IDLE : DATA;
          if (state_q == RD_REQ && !end_now)
            tx_d = bus.reg_rdata;
        end else if (tmo) begin
          addr_d  = addr_q + 1'b1;
          abort_d = 1'b0;
          terr_d  = 1'b1;
          state_d = end_now ? IDLE : DATA;
          if (state_q == RD_REQ && !end_now)
            tx_d = '1;
        end
      end
      DATA: begin
        if (rise) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          if (rw_q) begin
            state_d = RD_REQ;
          end else begin
            wdata_d = rx_byte;
            state_d = WR_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_q      <= '0;
      overrun_q <= 1'b0;
      terr_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
      terr_q    <= terr_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = (state_q == WR_REQ);
  assign bus.reg_re    = (state_q == RD_REQ);
  assign tx_byte       = tx_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Transaction controller for the SPI slave byte shifter. It runs in the system clock domain and consumes the slave's received bytes and chip-select, both already synchronised into this domain.
- It decodes a command byte, then sequences auto-incrementing register reads and writes over a simple req/ack register bus.
- It supplies the next byte the slave shifts out on MISO.
- It sits between the SPI slave and the device register file.

Parameters:
- DATA_W, 8, SPI word and register data width. Address width is fixed at DATA_W-1.
- TIMEOUT, 255, max cycles a bus request may wait for ack. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cs_n  in  1  synchronised SPI chip select, active low
- rx_byte  in  DATA_W  byte received from the SPI slave; valid when rx_valid=1
- rx_valid  in  1  one-cycle pulse per completed SPI byte
- tx_byte  out  DATA_W  byte presented to the slave's parallel load input
- reg_addr  out  DATA_W-1  register bus address
- reg_wdata  out  DATA_W  register write data
- reg_we  out  1  write request, held until reg_ack
- reg_re  out  1  read request, held until reg_ack
- reg_rdata  in  DATA_W  read data; valid when reg_ack=1
- reg_ack  in  1  one-cycle bus completion
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: a byte arrived while a bus request was pending

Behaviour:
Reset values: all outputs 0, state=IDLE, cs_n_q=1.

Chip-select edges: registered cs_n_q gives fall = cs_n_q & ~cs_n and rise = ~cs_n_q & cs_n.

Status byte: STATUS = {DATA_W-2 zeros, timeout_err, overrun}. In IDLE, tx_byte = STATUS, updated every cycle.

States:
- IDLE: on fall -> CMD.
- CMD: on rx_valid, latch rw = rx_byte[DATA_W-1] and addr = rx_byte[DATA_W-2:0]. Clear overrun and timeout_err. Then rw=1 -> RD_REQ, rw=0 -> DATA.
- RD_REQ:
  - Assert reg_re with reg_addr = addr.
  - On reg_ack: tx_byte <= reg_rdata, addr <= addr+1, -> DATA.
  - Read data is thus prefetched before the next SPI byte starts.
- DATA: on rx_valid, rw=0 -> reg_wdata <= rx_byte, -> WR_REQ; rw=1 -> RD_REQ (prefetch the next address).
- WR_REQ: assert reg_we. On reg_ack: addr <= addr+1, -> DATA.

Bus rules:
- reg_we and reg_re are never both high.
- reg_addr and reg_wdata are stable while a request is asserted.
- Request asserts on the cycle after state entry and deasserts in the cycle following reg_ack.

Rules:
- Address wrap: addr is DATA_W-1 bits and wraps modulo 2^(DATA_W-1); 127 -> 0 at the default width.
- rise in CMD or DATA -> IDLE immediately. A partial command has no effect.
- rise in RD_REQ or WR_REQ: the request is held until reg_ack (never dropped mid-handshake), then -> IDLE. A read result is discarded.
- rx_valid in RD_REQ or WR_REQ: byte dropped, overrun <= 1, state unchanged.
- fall and rx_valid in the same cycle in IDLE: fall wins and rx_valid is ignored.
- rx_valid in IDLE: ignored.
- rst mid-transaction: immediate return to IDLE with requests deasserted. The bus slave must tolerate a request dropped by reset.

Optional Feature:
SPI_REG_CTRL_TIMEOUT_EN
- Defined:
  - A counter runs in RD_REQ and WR_REQ.
  - After TIMEOUT cycles without reg_ack, the request is dropped and timeout_err <= 1 (sticky until the next CMD).
  - A read timeout loads tx_byte <= all-ones.
  - addr still increments and the state advances -> DATA, or -> IDLE if rise was seen.
- Undefined: no counter; requests wait indefinitely; timeout_err is tied 0.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum: IDLE, CMD, RD_REQ, WR_REQ, DATA
  - RW_BIT index constant
  - STATUS bit positions: OVERRUN_BIT=0, TIMEOUT_BIT=1
- No sub-module is required. The timeout counter may be split out as spi_reg_timeout.

Test Plan:
- Reset, then cs_n 1->0: tx_byte=8'h00, busy=1, state CMD.
- Write burst: cmd 8'h05 then data 8'hAA, 8'h55 -> reg_we at addr 5 with wdata AA, then addr 6 with wdata 55; one ack each; cs_n rise -> busy=0.
- Read burst: cmd 8'hFE (read, addr 7'h7E), regs return 8'h11, 8'h22, 8'h33 -> tx_byte 11, 22, 33 in order; addresses 7E, 7F, then wrap to 00.
- Overrun: delay reg_ack 20 cycles and pulse rx_valid during the wait -> overrun=1, byte dropped; next transaction shows STATUS=8'h01 in IDLE; cleared after that transaction's command byte.
- cs_n rise during pending WR_REQ: reg_we stays high until ack, then IDLE; no further bus activity.
- With SPI_REG_CTRL_TIMEOUT_EN and TIMEOUT=16, no ack on read: reg_re drops after 16 cycles, tx_byte=8'hFF, timeout_err=1, STATUS=8'h02.
